// File: rtl/uart_tx_datapath.sv
`default_nettype none
// ============================================================================
// uart_tx_datapath : UART transmit datapath (shift register, parity, bit
// counter, registered output mux). Optional frame counter: UART_TX_FRAME_CNT_EN
// Revision: 1.0
// ============================================================================
module uart_tx_datapath (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  P_DATA,
  input  logic        Data_Valid,
  input  logic        PAR_TYP,
  input  logic        busy,
  input  logic        ser_en,
  input  logic [1:0]  mux_sel,
  output logic        ser_done,
  output logic        TX_OUT,
  output logic        drop_flag
`ifdef UART_TX_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  localparam logic [1:0] SEL_START  = 2'b00;
  localparam logic [1:0] SEL_DATA   = 2'b01;
  localparam logic [1:0] SEL_PARITY = 2'b10;
  localparam logic [1:0] SEL_STOP   = 2'b11;
  localparam logic [3:0] BITS_LAST  = 4'd8;

  logic [7:0] shreg;
  logic       ser_bit;
  logic       parity_bit;
  logic [3:0] bit_cnt;
  logic       load;
  logic       tx_next;

  // A byte is only accepted between frames; offers while busy are dropped.
  assign load     = Data_Valid & ~busy;
  assign ser_done = (bit_cnt == BITS_LAST);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      shreg      <= 8'd0;
      ser_bit    <= 1'b0;
      parity_bit <= 1'b0;
      bit_cnt    <= 4'd0;
    end else if (load) begin
      shreg      <= P_DATA;
      parity_bit <= (^P_DATA) ^ PAR_TYP;
      bit_cnt    <= 4'd0;
    end else if (ser_en && (bit_cnt < BITS_LAST)) begin
      ser_bit    <= shreg[0];
      shreg      <= {1'b0, shreg[7:1]};
      bit_cnt    <= bit_cnt + 4'd1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      drop_flag <= 1'b0;
    end else if (Data_Valid && busy) begin
      drop_flag <= 1'b1;
    end
  end

  always_comb begin
    tx_next = 1'b1;
    case (mux_sel)
      SEL_START:  tx_next = 1'b0;
      SEL_DATA:   tx_next = ser_bit;
      SEL_PARITY: tx_next = parity_bit;
      SEL_STOP:   tx_next = 1'b1;
      default:    tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      TX_OUT <= 1'b1;
    end else begin
      TX_OUT <= tx_next;
    end
  end

`ifdef UART_TX_FRAME_CNT_EN
  logic stop_cond;
  logic stop_q;

  // Count once per STOP state: rising edge of (STOP selected while busy).
  assign stop_cond = (mux_sel == SEL_STOP) && busy;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stop_q    <= 1'b0;
      frame_cnt <= 16'd0;
    end else begin
      stop_q <= stop_cond;
      if (stop_cond && !stop_q) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_datapath.sv
`default_nettype none
// Testbench for uart_tx_datapath: table-driven frames, hand-written corner
// sequences and randomized frames checked against a frame-level reference.
module tb_uart_tx_datapath;

  logic        CLK;
  logic        RST;
  logic [7:0]  P_DATA;
  logic        Data_Valid;
  logic        PAR_TYP;
  logic        busy;
  logic        ser_en;
  logic [1:0]  mux_sel;
  logic        ser_done;
  logic        TX_OUT;
  logic        drop_flag;
`ifdef UART_TX_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  int tests  = 0;
  int failed = 0;
  logic        exp_drop;
  logic [15:0] exp_fc;

  uart_tx_datapath dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_TYP    (PAR_TYP),
    .busy       (busy),
    .ser_en     (ser_en),
    .mux_sel    (mux_sel),
    .ser_done   (ser_done),
    .TX_OUT     (TX_OUT),
    .drop_flag  (drop_flag)
`ifdef UART_TX_FRAME_CNT_EN
    ,
    .frame_cnt  (frame_cnt)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] data;
    logic       pt;
    logic       exp_par;
    bit         drop;
  } vec_t;

  task automatic check(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Frame-level parity rule: even parity makes the total count of ones even.
  function automatic logic ref_parity(input logic [7:0] d, input logic pt);
    int ones;
    ones = $countones(d);
    return ((ones % 2) == 1) ? ~pt : pt;
  endfunction

  task automatic idle_inputs();
    Data_Valid = 1'b0;
    busy       = 1'b0;
    ser_en     = 1'b0;
    mux_sel    = 2'b11;
  endtask

  task automatic do_reset();
    idle_inputs();
    RST = 1'b1;
    step();
    check("rst_tx",   TX_OUT,    1'b1);
    check("rst_done", ser_done,  1'b0);
    check("rst_drop", drop_flag, 1'b0);
`ifdef UART_TX_FRAME_CNT_EN
    check16("rst_fc", frame_cnt, 16'h0000);
`endif
    RST      = 1'b0;
    exp_drop = 1'b0;
    exp_fc   = 16'd0;
  endtask

  // One controller frame: [gap idles] LOAD, START, DATA x8, PARITY, STOP.
  // Expected TX_OUT after each edge: 1 (load), 0, d[0..7], parity, 1.
  task automatic send_frame(input logic [7:0] d, input logic pt, input logic ep,
                            input bit drop, input int gap, input bit extra_en);
    for (int g = 0; g < gap; g++) begin
      idle_inputs();
      step();
      check("idle_tx", TX_OUT, 1'b1);
    end
    Data_Valid = 1'b1; busy = 1'b0; P_DATA = d; PAR_TYP = pt;
    mux_sel = 2'b11; ser_en = extra_en;
    step();
    check("load_tx",   TX_OUT,   1'b1);
    check("load_done", ser_done, 1'b0);
    Data_Valid = 1'b0; busy = 1'b1; mux_sel = 2'b00; ser_en = 1'b1;
    P_DATA = 8'($urandom); PAR_TYP = 1'($urandom);
    step();
    check("start_tx", TX_OUT, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      mux_sel = 2'b01;
      ser_en  = (k == 8) ? extra_en : 1'b1;
      if (drop && k == 3) begin
        Data_Valid = 1'b1;
        P_DATA     = 8'hFF;
      end
      check("data_done", ser_done, (k == 8));
      step();
      if (drop && k == 3) exp_drop = 1'b1;
      Data_Valid = 1'b0;
      check("data_tx", TX_OUT, d[k-1]);
    end
    mux_sel = 2'b10; ser_en = extra_en;
    step();
    check("par_tx",   TX_OUT,   ep);
    check("par_done", ser_done, 1'b1);
    mux_sel = 2'b11;
    step();
    exp_fc = exp_fc + 16'd1;
    check("stop_tx",   TX_OUT,    1'b1);
    check("stop_done", ser_done,  1'b1);
    check("drop_flag", drop_flag, exp_drop);
`ifdef UART_TX_FRAME_CNT_EN
    check16("frame_cnt", frame_cnt, exp_fc);
`endif
    busy = 1'b0; ser_en = 1'b0;
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'h01, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{8'h80, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{8'h7F, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{8'h00, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{8'hC3, 1'b1, 1'b1, 1'b1};
    vecs[7] = '{8'h5A, 1'b0, 1'b0, 1'b0};

    P_DATA = 8'h00; PAR_TYP = 1'b0; exp_drop = 1'b0; exp_fc = 16'd0;
    idle_inputs();
    RST = 1'b1;
    #2;
    check("async_rst_tx", TX_OUT, 1'b1);
    do_reset();

    // Back-to-back frames with no idle cycle between them.
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    send_frame(8'hAA, 1'b1, 1'b1, 1'b0, 0, 1'b0);
`ifdef UART_TX_FRAME_CNT_EN
    check16("b2b_fc", frame_cnt, 16'd2);
`endif

    for (int i = 0; i < 8; i++) begin
      send_frame(vecs[i].data, vecs[i].pt, vecs[i].exp_par, vecs[i].drop, i % 2, 1'(i / 4));
    end
    check("drop_sticky", drop_flag, 1'b1);

    // Abort a frame of 0x96 after its 4th data bit is on the line (bit3 = 0).
    Data_Valid = 1'b1; busy = 1'b0; P_DATA = 8'h96; PAR_TYP = 1'b0; mux_sel = 2'b11;
    step();
    Data_Valid = 1'b0; busy = 1'b1; mux_sel = 2'b00; ser_en = 1'b1;
    step();
    mux_sel = 2'b01;
    repeat (4) step();
    check("pre_abort_tx", TX_OUT, 1'b0);
    RST = 1'b1;
    #1;
    check("abort_tx",   TX_OUT,    1'b1);
    check("abort_done", ser_done,  1'b0);
    check("abort_drop", drop_flag, 1'b0);
    idle_inputs();
    step();
    RST = 1'b0; exp_drop = 1'b0; exp_fc = 16'd0;
    step();
    check("post_abort_tx", TX_OUT, 1'b1);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [7:0] d;
      logic       pt;
      d  = 8'($urandom);
      pt = 1'($urandom);
      send_frame(d, pt, ref_parity(d, pt), ($urandom_range(0, 7) == 0),
                 int'($urandom_range(0, 2)), 1'($urandom));
    end

`ifdef UART_TX_FRAME_CNT_EN
    force dut.frame_cnt = 16'hFFFF;
    #1;
    release dut.frame_cnt;
    exp_fc = 16'hFFFF;
    send_frame(8'h12, 1'b0, 1'b0, 1'b0, 1, 1'b0);
    check16("fc_wrap", frame_cnt, 16'h0000);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_datapath.md
UART_TX_DATAPATH -- requirements
Module: uart_tx_datapath

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named CLK and RST.
REQ-002 Port CLK  input  1  system clock; all state updates on the rising edge.
REQ-003 Port RST  input  1  asynchronous reset, active-high.
REQ-004 Port P_DATA  input  8  parallel byte to transmit.
REQ-005 Port Data_Valid  input  1  P_DATA valid this cycle.
REQ-006 Port PAR_TYP  input  1  parity type: 0 = even, 1 = odd.
REQ-007 Port busy  input  1  frame in progress, driven by the TX controller.
REQ-008 Port ser_en  input  1  shift enable, driven by the TX controller.
REQ-009 Port mux_sel  input  2  output select: 00 start, 01 data, 10 parity, 11 stop/idle.
REQ-010 Port ser_done  output  1  all 8 data bits have been presented.
REQ-011 Port TX_OUT  output  1  serial line, registered.
REQ-012 Port drop_flag  output  1  sticky flag: a byte was offered while busy.
REQ-013 Port frame_cnt  output  16  completed-frame count; present only under UART_TX_FRAME_CNT_EN.

Function
REQ-014 Load: when Data_Valid=1 and busy=0, the block SHALL latch P_DATA into the 8-bit shift register and the parity of P_DATA/PAR_TYP into the parity register, and SHALL clear the bit counter.
REQ-015 Parity rule: parity_bit = XOR(P_DATA) for PAR_TYP=0, and ~XOR(P_DATA) for PAR_TYP=1; it is fixed at load time.
REQ-016 Load vs busy: Data_Valid=1 with busy=1 SHALL NOT disturb the shift register, the parity register or the counter, and SHALL set drop_flag.
REQ-017 drop_flag SHALL clear only on reset.
REQ-018 Shift: on each edge with ser_en=1 and counter<8:
  - ser_bit <= shreg[0]
  - shreg shifts right, LSB first
  - counter increments by 1.
REQ-019 When ser_en=1 and counter=8, the block SHALL NOT shift and SHALL NOT increment the counter; the counter saturates at 8.
REQ-020 ser_done SHALL be combinational and equal to (counter==8).
REQ-021 The counter SHALL be 4 bits and SHALL NOT wrap.
REQ-022 Timing contract: a START cycle (ser_en=1) followed by 7 DATA cycles with ser_en=1 SHALL give 8 shifts, so ser_done=1 in the 8th DATA cycle while bit7 is on ser_bit.
REQ-023 Output mux: the next value of TX_OUT SHALL be selected by mux_sel:
  - 00 -> 0
  - 01 -> ser_bit
  - 10 -> parity_bit
  - 11 -> 1.
REQ-024 Latency: TX_OUT SHALL be registered, lagging mux_sel by exactly one cycle.
REQ-025 Simultaneous load and ser_en: a load SHALL take priority over a shift; this can only occur when busy=0.
REQ-026 Back-to-back frames: a load on the cycle busy first drops to 0 SHALL be accepted without a gap cycle.

Reset
REQ-027 While RST=1, the block SHALL hold: TX_OUT=1, shreg=0, ser_bit=0, parity_bit=0, counter=0, ser_done=0, drop_flag=0, frame_cnt=0.
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately, with TX_OUT=1 from that point.
REQ-029 After reset release, the first valid load SHALL start cleanly.

Configuration
REQ-030 With macro UART_TX_FRAME_CNT_EN defined, the block SHALL provide frame_cnt[15:0].
REQ-031 frame_cnt SHALL increment by 1 on every rising edge of the condition (mux_sel==11 and busy==1), i.e. once per STOP state.
REQ-032 frame_cnt SHALL wrap from 0xFFFF to 0x0000.
REQ-033 Without UART_TX_FRAME_CNT_EN, neither the frame_cnt port nor its counter logic SHALL exist; all other behaviour is identical.

Verification
REQ-034 Even-parity frame: P_DATA=0xA5, PAR_TYP=0, controller sequence START/DATA/PARITY/STOP -> TX_OUT = 0,1,0,1,0,0,1,0,1,0,1, one cycle after each mux_sel value.
REQ-035 Odd-parity frame: P_DATA=0x01, PAR_TYP=1 -> parity slot carries 0; ser_done rises in the 8th DATA cycle only.
REQ-036 Drop: Data_Valid pulsed with P_DATA=0xFF while busy=1 mid-frame -> the current frame bits are unchanged and drop_flag=1 until RST.
REQ-037 Mid-frame reset: RST asserted at the 4th data bit -> TX_OUT=1 and ser_done=0 asynchronously; the next frame with 0x3C transmits correctly.
REQ-038 Back-to-back frames: 0x55 then 0xAA with no idle cycle -> both frames are correct on TX_OUT; frame_cnt=2 with UART_TX_FRAME_CNT_EN.
REQ-039 frame_cnt wrap: frame_cnt forced to 0xFFFF, then one frame sent -> frame_cnt=0x0000.
